dcache_dm_wt: RTL and testbench

//  Parametrised direct-mapped, write-through, no-write-allocate data cache between core LSU and

---
 rtl/cache_pkg.sv | 48 ++++
 rtl/cache_data_ram.sv | 34 +++
 rtl/dcache_dm_wt.sv | 188 ++++++++++++++++++
 tb/tb_dcache_dm_wt.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-through data cache.
// Helpers take field widths as arguments so one package serves any cache geometry.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RF_REQ,
        RF_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } cache_state_e;

    // Word-within-line offset of a window-relative byte address.
    function automatic logic [31:0] adr_woff(input logic [31:0] loc, input int unsigned ob,
                                             input int unsigned wob);
        return (loc & ((32'd1 << ob) - 32'd1)) >> wob;
    endfunction

    function automatic logic [31:0] adr_idx(input logic [31:0] loc, input int unsigned ob,
                                            input int unsigned ib);
        return (loc >> ob) & ((32'd1 << ib) - 32'd1);
    endfunction

    function automatic logic [31:0] adr_tag(input logic [31:0] loc, input int unsigned ob,
                                            input int unsigned ib);
        return loc >> (ob + ib);
    endfunction

    // Subtract only after the lower bound holds so the difference cannot wrap.
    function automatic logic in_window(input logic [31:0] adr, input logic [31:0] base,
                                       input logic [31:0] span);
        return (adr >= base) && ((adr - base) < span);
    endfunction

    // Byte-lane merge sized for the widest supported word; callers cast to their width.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                               input logic [7:0] be);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Single-port line store: SETS*LINE_WORDS words, per-byte write enables, registered read.
// Read data holds until the next read enable; writes leave o_rdata unchanged.
module cache_data_ram
    import cache_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_adr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN/8-1:0] i_be,
    output logic [XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_adr] <= XLEN'(strb_merge(64'(r_mem[i_adr]), 64'(i_wdata), 8'(i_be)));
            end else begin
                r_rdata <= r_mem[i_adr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between LSU and single-beat memory.
// Hit read responds 2 cycles after accept; misses refill the whole line then re-run the lookup.
module dcache_dm_wt
    import cache_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0002_0000,
    parameter int          XLEN       = 32,
    parameter int          LINE_WORDS = 4,
    parameter int          SETS       = 256,
    parameter logic [31:0] SPAN       = 32'h0010_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_v,
    output logic              req_rdy,
    input  logic              req_we,
    input  logic [31:0]       req_adr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [XLEN/8-1:0] req_strb,
    output logic              resp_v,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    input  logic              flush,
    output logic              mem_req_v,
    input  logic              mem_req_rdy,
    output logic              mem_we,
    output logic [31:0]       mem_adr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_strb,
    input  logic              mem_rsp_v,
    input  logic [XLEN-1:0]   mem_rsp_data
);

    localparam int SB  = XLEN / 8;
    localparam int WOB = $clog2(SB);
    localparam int WB  = $clog2(LINE_WORDS);
    localparam int OB  = WB + WOB;
    localparam int IB  = $clog2(SETS);
    localparam int TB  = 32 - OB - IB;
    localparam int AW  = IB + WB;

    cache_state_e    r_state, w_next;
    logic [31:0]     r_adr;
    logic            r_we;
    logic [XLEN-1:0] r_data;
    logic [SB-1:0]   r_strb;
    logic            r_err;
    logic [WB-1:0]   r_beat;
    logic [SETS-1:0] r_valid;
    logic [TB-1:0]   r_tag [SETS];
    logic            r_flush_pend;

    logic [31:0]     w_local;
    logic [IB-1:0]   w_idx;
    logic [TB-1:0]   w_tag;
    logic [WB-1:0]   w_woff;
    logic            w_bad, w_hit, w_last, w_accept, w_flush_now;
    logic            w_rf, w_wr;
    logic            w_ram_en, w_ram_we;
    logic [AW-1:0]   w_ram_adr;
    logic [XLEN-1:0] w_ram_wdata, w_ram_rdata;
    logic [SB-1:0]   w_ram_be;

    assign w_local     = r_adr - BASE_ADDR;
    assign w_idx       = IB'(adr_idx(w_local, OB, IB));
    assign w_tag       = TB'(adr_tag(w_local, OB, IB));
    assign w_woff      = WB'(adr_woff(w_local, OB, WOB));
    assign w_bad       = (r_adr[WOB-1:0] != '0) || !in_window(r_adr, BASE_ADDR, SPAN);
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_last      = (r_beat == WB'(LINE_WORDS - 1));
    assign w_accept    = req_v && req_rdy;
    assign w_flush_now = (r_state == IDLE) && (flush || r_flush_pend);

    assign req_rdy = rst_n && (r_state == IDLE) && !flush && !r_flush_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_adr   = {w_idx, w_woff};
        w_ram_wdata = r_data;
        w_ram_be    = r_strb;
        case (r_state)
            IDLE:    if (w_accept) w_next = LOOKUP;
            LOOKUP: begin
                if (w_bad) begin
                    w_next = RESP;
                end else if (r_we) begin
                    w_ram_en = w_hit;
                    w_ram_we = w_hit;
                    w_next   = WR_REQ;
                end else begin
                    w_ram_en = 1'b1;
                    w_next   = w_hit ? RESP : RF_REQ;
                end
            end
            RF_REQ:  if (mem_req_rdy) w_next = RF_WAIT;
            RF_WAIT: begin
                if (mem_rsp_v) begin
                    w_ram_en    = 1'b1;
                    w_ram_we    = 1'b1;
                    w_ram_adr   = {w_idx, r_beat};
                    w_ram_wdata = mem_rsp_data;
                    w_ram_be    = '1;
                    // The port is busy writing, so the requested word is fetched by a second lookup.
                    w_next      = w_last ? LOOKUP : RF_REQ;
                end
            end
            WR_REQ:  if (mem_req_rdy) w_next = WR_WAIT;
            WR_WAIT: if (mem_rsp_v) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_strb       <= '0;
            r_err        <= 1'b0;
            r_beat       <= '0;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_adr  <= req_adr;
                r_we   <= req_we;
                r_data <= req_data;
                r_strb <= req_strb;
                r_err  <= 1'b0;
            end
            if (r_state == LOOKUP) begin
                r_err  <= w_bad;
                r_beat <= '0;
            end
            if (r_state == RF_WAIT && mem_rsp_v) begin
                r_beat <= r_beat + 1'b1;
                if (w_last) r_valid[w_idx] <= 1'b1;
            end
            if (w_flush_now) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_state == RF_WAIT && mem_rsp_v && w_last) r_tag[w_idx] <= w_tag;
    end

    cache_data_ram #(
        .XLEN  (XLEN),
        .DEPTH (SETS * LINE_WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_adr   (w_ram_adr),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_rdata (w_ram_rdata)
    );

    assign resp_v    = rst_n && (r_state == RESP);
    assign resp_err  = resp_v && r_err;
    assign resp_data = (resp_v && !r_err && !r_we) ? w_ram_rdata : '0;

    // Window base is line aligned, so the line base keeps the request's upper bits.
    assign w_rf      = rst_n && (r_state == RF_REQ);
    assign w_wr      = rst_n && (r_state == WR_REQ);
    assign mem_req_v = w_rf || w_wr;
    assign mem_we    = w_wr;
    assign mem_adr   = w_rf ? {r_adr[31:OB], r_beat, WOB'(0)} :
                       w_wr ? {r_adr[31:WOB], WOB'(0)} : 32'd0;
    assign mem_wdata = w_wr ? r_data : '0;
    assign mem_strb  = w_wr ? r_strb : (w_rf ? '1 : '0);

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed bench for dcache_dm_wt: vector table plus flush, stall and reset-mid-refill sequences.
module tb_dcache_dm_wt;

    localparam logic [31:0] PAT = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_v, req_rdy, req_we;
    logic [31:0] req_adr, req_data;
    logic [3:0]  req_strb;
    logic        resp_v, resp_err;
    logic [31:0] resp_data;
    logic        flush;
    logic        mem_req_v, mem_req_rdy, mem_we;
    logic [31:0] mem_adr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_rsp_v;
    logic [31:0] mem_rsp_data;

    always #5 clk = ~clk;

    dcache_dm_wt dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_v        (req_v),
        .req_rdy      (req_rdy),
        .req_we       (req_we),
        .req_adr      (req_adr),
        .req_data     (req_data),
        .req_strb     (req_strb),
        .resp_v       (resp_v),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .flush        (flush),
        .mem_req_v    (mem_req_v),
        .mem_req_rdy  (mem_req_rdy),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_strb     (mem_strb),
        .mem_rsp_v    (mem_rsp_v),
        .mem_rsp_data (mem_rsp_data)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [3:0]  st;
    } mtx_t;

    logic [31:0] mem_m [int unsigned];
    mtx_t        mlog [$];
    int          mem_cnt = 0;
    int          stall = 0;
    int          stall_bad = 0;
    bit          stalled = 0;
    logic [31:0] st_adr, st_wd;
    bit          pend = 0;
    logic [31:0] pend_d;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ PAT;
    endfunction

    initial begin
        mem_req_rdy  = 1'b1;
        mem_rsp_v    = 1'b0;
        mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            mem_rsp_v    = 1'b0;
            mem_rsp_data = '0;
            if (pend) begin
                mem_rsp_v    = 1'b1;
                mem_rsp_data = pend_d;
                pend         = 0;
            end
            if (mem_req_v) begin
                if (stalled && (mem_adr !== st_adr || mem_wdata !== st_wd)) stall_bad++;
                if (stall > 0) begin
                    stalled     = 1;
                    st_adr      = mem_adr;
                    st_wd       = mem_wdata;
                    stall--;
                    mem_req_rdy = 1'b0;
                end else begin
                    logic [31:0] m;
                    stalled     = 0;
                    mem_req_rdy = 1'b1;
                    mlog.push_back('{we: mem_we, adr: mem_adr, wd: mem_wdata, st: mem_strb});
                    mem_cnt++;
                    if (mem_we) begin
                        m = mrd(mem_adr);
                        for (int b = 0; b < 4; b++)
                            if (mem_strb[b]) m[8*b +: 8] = mem_wdata[8*b +: 8];
                        mem_m[mem_adr] = m;
                        pend_d = '0;
                    end else begin
                        pend_d = mrd(mem_adr);
                    end
                    pend = 1;
                end
            end else begin
                mem_req_rdy = 1'b1;
            end
        end
    end

    // ---------------- request driver ----------------
    int zbad = 0;

    task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rd, output logic er,
                          output int lat, output int nmem, output bit got);
        int base;
        int n;
        @(negedge clk);
        mlog.delete();
        base     = mem_cnt;
        req_v    = 1'b1;
        req_we   = we;
        req_adr  = adr;
        req_data = data;
        req_strb = strb;
        rd = '0; er = 1'b0; got = 0;
        n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_v = 1'b0;
        lat = 1;
        while (lat < 400) begin
            if (resp_v) begin
                got = 1;
                rd  = resp_data;
                er  = resp_err;
                break;
            end
            if (resp_data !== 32'd0 || resp_err !== 1'b0) zbad++;
            @(negedge clk);
            lat++;
        end
        nmem = mem_cnt - base;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_mem;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mkv(input logic we, input logic [31:0] adr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [31:0] ed, input logic ee,
                                 input int em, input int el);
        vec_t v;
        v.we = we; v.adr = adr; v.data = data; v.strb = strb;
        v.exp_data = ed; v.exp_err = ee; v.exp_mem = em; v.exp_lat = el;
        return v;
    endfunction

    vec_t        vecs [16];
    logic [31:0] rd;
    logic        er;
    int          lat, nmem, base;
    bit          got, ok;
    int          n;

    initial begin
        rst_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_adr = '0;
        req_data = '0; req_strb = '0; flush = 1'b0;

        vecs[0]  = mkv(0, 32'h0002_0010, 0, 0, 32'h0002_0010 ^ PAT, 0, 4, 0);
        vecs[1]  = mkv(0, 32'h0002_0014, 0, 0, 32'h0002_0014 ^ PAT, 0, 0, 2);
        vecs[2]  = mkv(1, 32'h0002_0014, 32'hAABB_CCDD, 4'b0011, 0, 0, 1, 0);
        vecs[3]  = mkv(0, 32'h0002_0014, 0, 0, 32'h5A58_CCDD, 0, 0, 2);
        vecs[4]  = mkv(0, 32'h0002_0013, 0, 0, 0, 1, 0, 2);
        vecs[5]  = mkv(0, 32'h0001_FFFC, 0, 0, 0, 1, 0, 2);
        vecs[6]  = mkv(0, 32'h0012_0000, 0, 0, 0, 1, 0, 2);
        vecs[7]  = mkv(0, 32'h0011_FFFC, 0, 0, 32'h0011_FFFC ^ PAT, 0, 4, 0);
        vecs[8]  = mkv(1, 32'h0002_0018, 32'h1234_5678, 4'b0000, 0, 0, 1, 0);
        vecs[9]  = mkv(0, 32'h0002_0018, 0, 0, 32'h0002_0018 ^ PAT, 0, 0, 2);
        vecs[10] = mkv(1, 32'h0002_0100, 32'hCAFE_F00D, 4'b1111, 0, 0, 1, 0);
        vecs[11] = mkv(0, 32'h0002_0100, 0, 0, 32'hCAFE_F00D, 0, 4, 0);
        vecs[12] = mkv(0, 32'h0002_010C, 0, 0, 32'h0002_010C ^ PAT, 0, 0, 2);
        vecs[13] = mkv(0, 32'h0002_0000, 0, 0, 32'h0002_0000 ^ PAT, 0, 4, 0);
        vecs[14] = mkv(0, 32'h0002_1000, 0, 0, 32'h0002_1000 ^ PAT, 0, 4, 0);
        vecs[15] = mkv(0, 32'h0002_0000, 0, 0, 32'h0002_0000 ^ PAT, 0, 4, 0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_resp_v", 32'(resp_v), 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_req_v", 32'(mem_req_v), 0);
        chk("rst_mem_adr", mem_adr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_rdy", 32'(req_rdy), 1);

        foreach (vecs[i]) begin
            do_req(vecs[i].we, vecs[i].adr, vecs[i].data, vecs[i].strb, rd, er, lat, nmem, got);
            chk($sformatf("v%0d_got_resp", i), 32'(got), 1);
            chk($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_mem_cnt", i), 32'(nmem), 32'(vecs[i].exp_mem));
            if (vecs[i].exp_lat != 0)
                chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_mem == 4) begin
                ok = 1;
                for (int k = 0; k < 4; k++)
                    if (mlog.size() <= k || mlog[k].we !== 1'b0 ||
                        mlog[k].adr !== ({vecs[i].adr[31:4], 4'h0} + 32'(4 * k))) ok = 0;
                chk($sformatf("v%0d_refill_adrs", i), 32'(ok), 1);
            end
            if (vecs[i].we && mlog.size() > 0) begin
                chk($sformatf("v%0d_wr_adr", i), mlog[0].adr, vecs[i].adr);
                chk($sformatf("v%0d_wr_we_strb", i), {27'd0, mlog[0].we, mlog[0].st},
                    {27'd0, 1'b1, vecs[i].strb});
                chk($sformatf("v%0d_wr_data", i), mlog[0].wd, vecs[i].data);
            end
        end

        // flush while idle: request blocked that cycle, line misses afterwards
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_idle_rdy_low", 32'(req_rdy), 0);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_idle_rdy_back", 32'(req_rdy), 1);
        do_req(0, 32'h0002_0010, 0, 0, rd, er, lat, nmem, got);
        chk("flush_idle_remiss", 32'(nmem), 4);
        chk("flush_idle_data", rd, 32'h0002_0010 ^ PAT);

        // flush during refill: response still delivered, line invalid afterwards
        base = mem_cnt;
        fork
            do_req(0, 32'h0002_0204, 0, 0, rd, er, lat, nmem, got);
            begin
                n = 0;
                while (mem_cnt <= base && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        chk("flush_rf_got", 32'(got), 1);
        chk("flush_rf_data", rd, 32'h0002_0204 ^ PAT);
        chk("flush_rf_mem", 32'(nmem), 4);
        do_req(0, 32'h0002_0204, 0, 0, rd, er, lat, nmem, got);
        chk("flush_rf_remiss", 32'(nmem), 4);

        // memory stall on a write: request must hold steady
        stall = 3;
        do_req(1, 32'h0002_0208, 32'h0102_0304, 4'hF, rd, er, lat, nmem, got);
        chk("stall_got", 32'(got), 1);
        chk("stall_mem_cnt", 32'(nmem), 1);
        chk("stall_stable", 32'(stall_bad), 0);
        chk("stall_latency_ge", 32'(lat >= 6), 1);
        do_req(0, 32'h0002_0208, 0, 0, rd, er, lat, nmem, got);
        chk("stall_readback", rd, 32'h0102_0304);
        chk("stall_readback_hit", 32'(nmem), 0);

        // reset in the middle of a refill
        @(negedge clk);
        base    = mem_cnt;
        req_v   = 1'b1;
        req_we  = 1'b0;
        req_adr = 32'h0002_0300;
        n = 0;
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_v = 1'b0;
        n = 0;
        while (mem_cnt < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        #1 chk("rst_mid_mem_req_v", 32'(mem_req_v), 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_v) n++;
        end
        chk("rst_mid_no_resp", 32'(n), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_req(0, 32'h0002_0300, 0, 0, rd, er, lat, nmem, got);
        chk("rst_mid_remiss", 32'(nmem), 4);
        chk("rst_mid_data", rd, 32'h0002_0300 ^ PAT);

        chk("resp_zero_when_idle", 32'(zbad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
